// File: rtl/approx_div_pkg.sv
// Shared state encodings and cell/mask helpers for the sequential approximate divider.
package approx_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Exact full subtractor cell, returns {diff, bout}.
    function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic bin);
        logic diff;
        logic bout;
        diff = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
        return {diff, bout};
    endfunction

    // Approximate subtractor cell, returns {diff, bout}.
    function automatic logic [1:0] approx_cell(input logic x, input logic y, input logic bin);
        logic diff;
        logic bout;
        diff = x & (~y | ~bin);
        bout = (~x & y) | (x & bin);
        return {diff, bout};
    endfunction

    // Bit j is set when cell (row, j) lies inside the approximate triangle.
    function automatic logic [31:0] approx_mask(input int row, input int depth, input int w);
        logic [31:0] m;
        m = 32'd0;
        for (int j = 0; j < 32; j++) begin
            if ((j < w) && ((row + j) < depth)) begin
                m[j] = 1'b1;
            end else begin
                m[j] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/approx_div_row.sv
// One combinational restoring-division row with per-column exact/approximate cell selection.
module approx_div_row
    import approx_div_pkg::*;
#(
    parameter int D_W = 8
) (
    input  logic [D_W-1:0] x,
    input  logic           t,
    input  logic [D_W-1:0] d,
    input  logic [D_W-1:0] mask,
    output logic           q_bit,
    output logic [D_W-1:0] row_r
);

    logic [D_W-1:0] diff_s;
    logic           bout_s;

    // Ripple the borrow from column 0 upward, choosing the cell type per column.
    always_comb begin
        logic [1:0] cell_v;
        logic       bin_v;
        bin_v  = 1'b0;
        diff_s = '0;
        for (int j = 0; j < D_W; j++) begin
            if (mask[j]) begin
                cell_v = approx_cell(x[j], d[j], bin_v);
            end else begin
                cell_v = exact_cell(x[j], d[j], bin_v);
            end
            diff_s[j] = cell_v[1];
            bin_v     = cell_v[0];
        end
        bout_s = bin_v;
    end

    // A quotient bit of 1 keeps the difference, otherwise the row restores x.
    always_comb begin
        q_bit = t | ~bout_s;
        if (q_bit) begin
            row_r = diff_s;
        end else begin
            row_r = x;
        end
    end

endmodule

// File: rtl/approx_div_seq.sv
// Sequential approximate divider: one quotient row per clock behind valid/ready handshakes.
module approx_div_seq
    import approx_div_pkg::*;
#(
    parameter int D_W          = 8,
    parameter int APPROX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*D_W-1:0] n,
    input  logic [D_W-1:0]   d,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_W-1:0]   q,
    output logic [D_W-1:0]   r,
    output logic             dz
);

    localparam int                CNT_W    = $clog2(D_W);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(D_W - 1);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2*D_W-1:0] n_r;
    logic [D_W-1:0]   d_r;
    logic             ae_r;
    logic [D_W-1:0]   prev_r;
    logic [D_W-1:0]   q_acc_r;
    logic [D_W-1:0]   q_r;
    logic [D_W-1:0]   r_r;
    logic             dz_r;

    logic [D_W-1:0]   x_s;
    logic             t_s;
    logic [D_W-1:0]   mask_s;
    logic             q_bit_s;
    logic [D_W-1:0]   row_r_s;

    // The first row reads the dividend top directly; later rows shift in one dividend bit.
    always_comb begin
        if (cnt_r == LAST_ROW) begin
            x_s = n_r[2*D_W-2:D_W-1];
            t_s = n_r[2*D_W-1];
        end else begin
            x_s = {prev_r[D_W-2:0], n_r[cnt_r]};
            t_s = prev_r[D_W-1];
        end
        if (ae_r) begin
            mask_s = D_W'(approx_mask(32'(cnt_r), APPROX_DEPTH, D_W));
        end else begin
            mask_s = '0;
        end
    end

    approx_div_row #(
        .D_W (D_W)
    ) u_row (
        .x     (x_s),
        .t     (t_s),
        .d     (d_r),
        .mask  (mask_s),
        .q_bit (q_bit_s),
        .row_r (row_r_s)
    );

    // Control FSM with operand capture, row iteration and result latching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            n_r     <= '0;
            d_r     <= '0;
            ae_r    <= 1'b0;
            prev_r  <= '0;
            q_acc_r <= '0;
            q_r     <= '0;
            r_r     <= '0;
            dz_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        n_r     <= n;
                        d_r     <= d;
                        ae_r    <= approx_en;
                        cnt_r   <= LAST_ROW;
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    prev_r         <= row_r_s;
                    q_acc_r[cnt_r] <= q_bit_s;
                    if (cnt_r == '0) begin
                        q_r     <= {q_acc_r[D_W-1:1], q_bit_s};
                        r_r     <= row_r_s;
                        dz_r    <= (d_r == '0);
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign q         = q_r;
    assign r         = r_r;
    assign dz        = dz_r;

endmodule

// File: tb/tb_approx_div_seq.sv
// Directed table-driven bench for approx_div_seq (D_W=8, APPROX_DEPTH=4).
module tb_approx_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n;
    logic [7:0]  d;
    logic        approx_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic        ae;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;

    vec_t vecs [11];

    approx_div_seq #(
        .D_W          (8),
        .APPROX_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .d         (d),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand set, wait for acceptance, then count edges until out_valid.
    task automatic do_op(input logic [15:0] nn, input logic [7:0] dd, input logic ae,
                         output int lat, output logic rdy);
        logic done;
        rdy       = in_ready;
        n         = nn;
        d         = dd;
        approx_en = ae;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        n         = ~nn;
        d         = ~dd;
        approx_en = ~ae;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) done = 1'b1;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic rdy;
        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0]  = '{16'd100,   8'd7,   1'b0, 8'd14,  8'd2,   1'b0};
        vecs[1]  = '{16'd1000,  8'd16,  1'b1, 8'd62,  8'd8,   1'b0};
        vecs[2]  = '{16'd15,    8'd15,  1'b1, 8'd1,   8'd15,  1'b0};
        vecs[3]  = '{16'd15,    8'd15,  1'b0, 8'd1,   8'd0,   1'b0};
        vecs[4]  = '{16'h1234,  8'd0,   1'b0, 8'hFF,  8'h34,  1'b1};
        vecs[5]  = '{16'h1234,  8'd0,   1'b1, 8'hFF,  8'h34,  1'b1};
        vecs[6]  = '{16'd4660,  8'd86,  1'b0, 8'd54,  8'd16,  1'b0};
        vecs[7]  = '{16'd65279, 8'd255, 1'b0, 8'd255, 8'd254, 1'b0};
        vecs[8]  = '{16'd0,     8'd5,   1'b1, 8'd1,   8'd0,   1'b0};
        vecs[9]  = '{16'd256,   8'd1,   1'b0, 8'hFF,  8'h01,  1'b0};
        vecs[10] = '{16'd255,   8'd1,   1'b0, 8'd255, 8'd0,   1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n         = 16'd0;
        d         = 8'd0;
        approx_en = 1'b0;
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset q", 32'(q), 32'd0);
        check("reset r", 32'(r), 32'd0);
        check("reset dz", 32'(dz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].n, vecs[i].d, vecs[i].ae, lat, rdy);
            check($sformatf("v%0d in_ready", i), 32'(rdy), 32'd1);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd8);
            check($sformatf("v%0d q", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("v%0d r", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("v%0d dz", i), 32'(dz), 32'(vecs[i].dz));
            release_out();
            check($sformatf("v%0d out_valid drop", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: hold DONE, poke in_valid, then release.
        do_op(16'd100, 8'd7, 1'b0, lat, rdy);
        check("bp latency", 32'(lat), 32'd8);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                n        = 16'd500;
                d        = 8'd3;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d q", c), 32'(q), 32'd14);
            check($sformatf("bp%0d r", c), 32'(r), 32'd2);
        end
        in_valid = 1'b0;
        release_out();
        check("bp released out_valid", 32'(out_valid), 32'd0);
        check("bp released in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp no phantom op", 32'(in_ready), 32'd1);

        // Reset mid-operation at row 3, then a clean transaction.
        n         = 16'd1000;
        d         = 8'd16;
        approx_en = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid busy in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst q", 32'(q), 32'd0);
        check("mid rst r", 32'(r), 32'd0);
        check("mid rst dz", 32'(dz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("post rst no out_valid", 32'(out_valid), 32'd0);
        end
        do_op(16'd100, 8'd7, 1'b0, lat, rdy);
        check("post rst in_ready", 32'(rdy), 32'd1);
        check("post rst latency", 32'(lat), 32'd8);
        check("post rst q", 32'(q), 32'd14);
        check("post rst r", 32'(r), 32'd2);
        release_out();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
